// File: rtl/hazard_unit.sv
// Load-use / branch / jump hazard controller for the 5-stage MIPS pipeline.
// Optional performance counters are enabled by defining HAZARD_PERF_EN.
module hazard_unit #(
    parameter int unsigned BRANCH_PENALTY = 3,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       ex_rt,
    input  logic             ex_MemRead,
    input  logic             id_Jump,
    input  logic             mem_BranchTaken,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IFIDFlush,
    output logic             flush,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic {StIdle, StSquash} state_e;

    // Detect cycle is the first flush cycle; cnt covers the rest minus the final one.
    localparam int unsigned SquashInit = (BRANCH_PENALTY > 1) ? BRANCH_PENALTY - 2 : 0;
    localparam logic [2:0]  CntInit    = 3'(SquashInit);

    state_e     r_state, w_state_nxt;
    logic [2:0] r_cnt, w_cnt_nxt;
    logic       w_load_use;
    logic       w_stall_evt;
    logic       w_flush_evt;

    assign w_load_use = ex_MemRead && (ex_rt != 5'd0) &&
                        ((ex_rt == id_rs) || (ex_rt == id_rt));

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= StIdle;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        IFIDFlush   = 1'b0;
        flush       = 1'b0;
        w_stall_evt = 1'b0;
        w_flush_evt = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (mem_BranchTaken) begin
                    flush       = 1'b1;
                    IFIDFlush   = 1'b1;
                    w_flush_evt = 1'b1;
                    if (BRANCH_PENALTY > 1) begin
                        w_state_nxt = StSquash;
                        w_cnt_nxt   = CntInit;
                    end
                end else if (id_Jump) begin
                    IFIDFlush   = 1'b1;
                    w_flush_evt = 1'b1;
                end else if (w_load_use) begin
                    PCWrite     = 1'b0;
                    IFIDWrite   = 1'b0;
                    flush       = 1'b1;
                    w_stall_evt = 1'b1;
                end
            end
            StSquash: begin
                flush     = 1'b1;
                IFIDFlush = 1'b1;
                if (r_cnt == 3'd0) begin
                    w_state_nxt = StIdle;
                end else begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
        // Hold the pipeline frozen and bubbled while reset is asserted.
        if (!resetN) begin
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            IFIDFlush   = 1'b1;
            flush       = 1'b1;
            w_stall_evt = 1'b0;
            w_flush_evt = 1'b0;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] r_stall_count, r_flush_count;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            if (w_stall_evt && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + 1'b1;
            end
            if (w_flush_evt && (r_flush_count != '1)) begin
                r_flush_count <= r_flush_count + 1'b1;
            end
        end
    end

    assign stall_count = r_stall_count;
    assign flush_count = r_flush_count;
`else
    logic w_unused_evt;
    assign w_unused_evt = w_stall_evt ^ w_flush_evt;
    assign stall_count  = '0;
    assign flush_count  = '0;
`endif

endmodule
